// File: rtl/byte_serial_adder_pkg.sv
// Shared definitions for the byte-serial adder: slice width, FSM encoding and
// the index-width helper.
package byte_serial_adder_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to index n bytes (n >= 2).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << r) < n) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/byte_serial_adder_carry_select8.sv
// CarrySelect8: 8-bit adder slice. The low nibble ripples and the high nibble is
// precomputed for both carry values, then selected by the low-nibble carry.
module CarrySelect8 (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_c,
   output logic [7:0] o_s,
   output logic       o_c
);

   logic [4:0] w_lo;
   logic [4:0] w_hi0;
   logic [4:0] w_hi1;
   logic [4:0] w_hi;

   assign w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_c};
   assign w_hi0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
   assign w_hi1 = w_hi0 + 5'd1;
   assign w_hi  = w_lo[4] ? w_hi1 : w_hi0;

   assign o_s = {w_hi[3:0], w_lo[3:0]};
   assign o_c = w_hi[4];

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder built from one 8-bit slice stepped LSB-first, one byte per clock,
// with valid/ready handshakes on the operand and result sides.
module byte_serial_adder
   import byte_serial_adder_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                     in_Clk,
   input  logic                     in_Rst,
   input  logic                     in_Valid,
   output logic                     out_Ready,
   input  logic [BYTE_W*NBYTES-1:0] in_A,
   input  logic [BYTE_W*NBYTES-1:0] in_B,
   input  logic                     in_C,
   output logic                     out_Valid,
   input  logic                     in_Ready,
   output logic [BYTE_W*NBYTES-1:0] out_S,
   output logic                     out_C,
   output logic                     out_V,
   output logic                     out_Busy
);

   localparam int IDX_W = clog2(NBYTES);

   // Handshake: a transfer occurs on a rising edge where valid and ready are
   // both high; ready/valid here come from registered state only.
   state_t                         r_state;
   state_t                         w_state_nxt;
   logic [NBYTES-1:0][BYTE_W-1:0]  r_a;
   logic [NBYTES-1:0][BYTE_W-1:0]  r_b;
   logic [NBYTES-1:0][BYTE_W-1:0]  r_s;
   logic [IDX_W-1:0]               r_idx;
   logic                           r_carry;
   logic                           r_c;
   logic                           r_v;
   logic                           w_last;
   logic [BYTE_W-1:0]              w_sum;
   logic                           w_cout;

   assign w_last = (r_idx == IDX_W'(NBYTES - 1));

   CarrySelect8 u_slice (
      .i_a (r_a[r_idx]),
      .i_b (r_b[r_idx]),
      .i_c (r_carry),
      .o_s (w_sum),
      .o_c (w_cout)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_Valid) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
         ST_DONE: if (in_Ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_Clk) begin
      if (in_Rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_c     <= 1'b0;
         r_v     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (in_Valid) begin
                  r_a     <= in_A;
                  r_b     <= in_B;
                  r_carry <= in_C;
                  r_idx   <= '0;
               end
            end
            ST_RUN: begin
               r_s[r_idx] <= w_sum;
               r_carry    <= w_cout;
               r_idx      <= r_idx + IDX_W'(1);
               // On the MSB byte the slice output carries the sign of the sum.
               if (w_last) begin
                  r_c <= w_cout;
                  r_v <= (r_a[NBYTES-1][BYTE_W-1] == r_b[NBYTES-1][BYTE_W-1]) &&
                         (w_sum[BYTE_W-1] != r_a[NBYTES-1][BYTE_W-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_Ready = (r_state == ST_IDLE);
   assign out_Busy  = (r_state == ST_RUN);
   assign out_Valid = (r_state == ST_DONE);
   assign out_S     = r_s;
   assign out_C     = r_c;
   assign out_V     = r_v;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder: driver tasks push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_byte_serial_adder;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk;
   logic          in_Rst;
   logic          in_Valid;
   logic          out_Ready;
   logic [W-1:0]  in_A;
   logic [W-1:0]  in_B;
   logic          in_C;
   logic          out_Valid;
   logic          in_Ready;
   logic [W-1:0]  out_S;
   logic          out_C;
   logic          out_V;
   logic          out_Busy;

   int            n_checks;
   int            n_errors;
   int            cyc;
   logic          prev_valid;
   logic [W+1:0]  exp_q[$];
   int            acc_q[$];

   byte_serial_adder #(.NBYTES(NB)) dut (
      .in_Clk    (clk),
      .in_Rst    (in_Rst),
      .in_Valid  (in_Valid),
      .out_Ready (out_Ready),
      .in_A      (in_A),
      .in_B      (in_B),
      .in_C      (in_C),
      .out_Valid (out_Valid),
      .in_Ready  (in_Ready),
      .out_S     (out_S),
      .out_C     (out_C),
      .out_V     (out_V),
      .out_Busy  (out_Busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (in_Rst) begin
         prev_valid = 1'b0;
      end else begin
         if (out_Valid && !prev_valid) begin
            if (acc_q.size() == 0) chk("unexpected_valid", 1, 0);
            else                   chk("latency", 64'(cyc - acc_q.pop_front()), 64'(NB));
         end
         if (out_Valid && in_Ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               logic [W+1:0] e;
               e = exp_q.pop_front();
               chk("sum", 64'(out_S), 64'(e[W-1:0]));
               chk("carry_out", 64'(out_C), 64'(e[W+1]));
               chk("overflow", 64'(out_V), 64'(e[W]));
            end
         end
         prev_valid = out_Valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int acc);
      logic rdy;
      acc = -1;
      in_A = a; in_B = b; in_C = c; in_Valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         rdy = out_Ready;
         @(posedge clk);
         if (rdy) begin
            acc = 0;
            break;
         end
      end
      #1;
      in_Valid = 1'b0;
      if (acc < 0) chk("accept_timeout", 1, 0);
      else         acc = cyc;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec, input logic ev,
                       output int acc);
      offer(a, b, c, acc);
      if (acc >= 0) begin
         exp_q.push_back({ec, ev, es});
         acc_q.push_back(acc);
      end
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      if (k == 100) chk("drain_timeout", 1, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acc, acc2, k;
      n_checks = 0; n_errors = 0;
      in_Rst = 1'b1; in_Valid = 1'b0; in_Ready = 1'b1;
      in_A = '0; in_B = '0; in_C = 1'b0;
      repeat (2) @(posedge clk);
      #1 in_Rst = 1'b0;

      @(negedge clk);
      chk("rst_ready", out_Ready, 1);
      chk("rst_valid", out_Valid, 0);
      chk("rst_busy",  out_Busy,  0);
      chk("rst_sum",   out_S,     0);
      chk("rst_c",     out_C,     0);
      chk("rst_v",     out_V,     0);
      @(posedge clk); #1;

      // 1: carry into byte 1; ready must stay low until the result is taken
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, acc);
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         chk("run_ready_low", out_Ready, 0);
         chk("run_busy", out_Busy, 1);
      end
      @(negedge clk);
      chk("done_valid", out_Valid, 1);
      chk("done_ready_low", out_Ready, 0);
      drain();

      // 2, 3: full carry ripple, all-ones, signed overflow
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, acc);
      drain();
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
      drain();
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, acc);
      drain();

      // 4: backpressure with a stray in_Valid during RUN/DONE
      in_Ready = 1'b0;
      send(32'h8000_0001, 32'h8000_0002, 1'b0, 32'h0000_0003, 1'b1, 1'b1, acc);
      in_A = 32'h0000_0001; in_B = 32'h0000_0001; in_C = 1'b0; in_Valid = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_Valid) break;
      end
      if (k == 20) chk("bp_valid_timeout", 1, 0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid_held", out_Valid, 1);
         chk("bp_sum_held", out_S, 32'h0000_0003);
         chk("bp_ready_low", out_Ready, 0);
         @(negedge clk);
      end
      in_Valid = 1'b0;
      @(posedge clk); #1;
      in_Ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_ready_after", out_Ready, 1);
      chk("bp_valid_after", out_Valid, 0);
      @(negedge clk);
      chk("bp_stray_not_taken", out_Busy, 0);
      @(posedge clk); #1;

      // 5: reset abort at byte index 2
      offer(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, acc);
      repeat (2) @(posedge clk);
      #1 in_Rst = 1'b1;
      @(posedge clk);
      #1 in_Rst = 1'b0;
      @(negedge clk);
      chk("abort_busy",  out_Busy,  0);
      chk("abort_valid", out_Valid, 0);
      chk("abort_ready", out_Ready, 1);
      chk("abort_sum",   out_S,     0);
      @(posedge clk); #1;
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, acc);
      drain();

      // 6: back-to-back with in_Ready high
      send(32'h0102_0304, 32'h1020_3040, 1'b0, 32'h1122_3344, 1'b0, 1'b0, acc);
      send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, acc2);
      if (acc >= 0 && acc2 >= 0) chk("accept_spacing", 64'(acc2 - acc), 64'(NB + 2));
      drain();
      chk("queue_empty", 64'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/byte_serial_adder.md
Name: byte_serial_adder

Overview:
Multi-byte operand sequencer that sits directly upstream of the team's 8-bit carry-select adder slice (CarrySelect8) and drives it one byte per clock.
- Accepts a wide A/B/carry-in operation over a valid/ready handshake.
- Steps the slice LSB-first, ripple-registering the carry between bytes.
- Returns the wide sum, carry-out and signed overflow over a second valid/ready handshake.
- Trades latency for area: one 8-bit slice serves any multiple-of-8 width.

Parameters:
NBYTES, 4, number of 8-bit bytes per operand; data width W = 8*NBYTES; legal range 2..16

Ports:
in_Clk  input  1  single clock; all state changes on rising edge
in_Rst  input  1  reset, synchronous, active-high
in_Valid  input  1  upstream offers an operation
out_Ready  output  1  block can accept an operation (high only in IDLE)
in_A  input  W  operand A
in_B  input  W  operand B
in_C  input  1  carry-in
out_Valid  output  1  result available (high only in DONE)
in_Ready  input  1  downstream accepts the result
out_S  output  W  sum
out_C  output  1  carry-out of the MSB
out_V  output  1  two's-complement overflow
out_Busy  output  1  high in RUN

Behaviour:
- Reset: synchronous, active-high; only sampled on the in_Clk rising edge.
- Reset state: state=IDLE, byte index=0, carry reg=0, out_S=0, out_C=0, out_V=0, out_Valid=0, out_Busy=0, out_Ready=1 (ready visible from the first cycle after reset).
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with in_Valid && out_Ready.
  - Register in_A, in_B and in_C into operand regs and the carry reg.
  - Set byte index=0.
- RUN, each edge: present operand byte[idx] and the carry reg to the slice combinationally.
  - Write the slice sum into result byte[idx].
  - Update carry reg with the slice carry-out.
  - idx++.
  - When idx==NBYTES-1 is processed, go to DONE.
- Latency: out_Valid rises exactly NBYTES edges after the accepting edge (4 for the default).
- Overflow and carry outputs:
  - out_V = (A[W-1]==B[W-1]) && (S[W-1]!=A[W-1]), registered with the final byte.
  - out_C = final carry reg.
- DONE: out_Valid=1; out_S, out_C and out_V are held stable until handshake.
  - On an edge with in_Ready=1: go to IDLE; out_Valid=0 and out_Ready=1 next cycle.
  - Results keep their value in IDLE until overwritten.
- No accept in the DONE-to-IDLE transition cycle; minimum spacing between accepts is NBYTES+2 cycles.
- in_A, in_B, in_C and in_Valid are ignored outside IDLE. Operand changes during RUN do not affect the result.
- in_Ready is ignored outside DONE.
- Reset mid-RUN or mid-DONE: the operation is discarded and all registers return to reset values on that edge. No out_Valid pulse is produced for the aborted operation.
- Reset has priority over any simultaneous handshake on the same edge.
- Wrap-around: the sum is modulo 2^W; the carry beyond the MSB appears only on out_C.
- out_Ready, out_Valid and out_Busy are decoded from registered state only, with no combinational path from in_Valid or in_Ready.

Decomposition:
- Shared package holds:
  - BYTE_W=8
  - state encoding localparams ST_IDLE, ST_RUN, ST_DONE
  - index width function clog2(NBYTES)
- One sub-module: the existing CarrySelect8 slice, instantiated once.
- Byte mux/demux and the FSM live in byte_serial_adder.

Test Plan:
1. A=0x000000FF, B=0x00000001, C=0, accept at edge E0 -> out_Valid high after E4; S=0x00000100, C=0, V=0; out_Ready low E0..DONE.
2. A=0xFFFFFFFF, B=0x00000000, C=1 -> S=0x00000000, out_C=1, V=0. The carry ripples through all four bytes.
3. A=0xFFFFFFFF, B=0xFFFFFFFF, C=1 -> S=0xFFFFFFFF, out_C=1, V=0. Then A=0x7FFFFFFF, B=0x00000001, C=0 -> S=0x80000000, out_C=0, V=1.
4. Backpressure and ignored inputs:
   - Hold in_Ready=0 for 3 cycles in DONE -> out_S and out_Valid stable; in_Valid pulsed during RUN/DONE is not accepted.
   - On in_Ready=1 -> out_Ready=1 on the next cycle.
5. Reset abort: assert in_Rst for one edge at byte index 2 of RUN -> next cycle out_Busy=0, out_Valid=0, out_Ready=1, out_S=0. A following A=0x12345678, B=0x11111111, C=0 yields S=0x23456789.
6. Back-to-back: two operations offered continuously with in_Ready tied high -> accepts spaced exactly NBYTES+2 cycles apart; both results correct.
